// File: rtl/fft_power_spectrum_if.sv
// rtl/fft_power_spectrum_if.sv - stream bundle between FFT output, power stage and mel filterbank
interface fft_power_spectrum_if #(
  parameter int unsigned BIN_W = 9
);
  logic [63:0]      in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [63:0]      out_power;
  logic [BIN_W-1:0] out_bin;
  logic             out_valid;
  logic             out_last;
  logic             out_ready;
  logic             frame_err;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_power, out_bin, out_valid, out_last, frame_err
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_power, out_bin, out_valid, out_last, frame_err
  );
endinterface

// File: rtl/fft_power_spectrum.sv
// rtl/fft_power_spectrum.sv - |z|^2 of FFT bins 0..FFT_SIZE/2, two-stage elastic pipeline
// Optional POWER_Q_SCALE_EN: round the Q2.62 power back to Q1.31 scale inside S2.
module fft_power_spectrum #(
  parameter int unsigned FFT_SIZE = 512,
  parameter int unsigned BIN_W    = $clog2(FFT_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  fft_power_spectrum_if.slave  bus
);

  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(FFT_SIZE - 1);
  localparam logic [BIN_W-1:0] HALF_BIN = BIN_W'(FFT_SIZE / 2);

  logic [BIN_W-1:0] in_bin_q, in_bin_d;
  logic             frame_err_q, frame_err_d;

  logic             s1_valid_q, s1_valid_d;
  logic [63:0]      s1_sq_re_q, s1_sq_re_d;
  logic [63:0]      s1_sq_im_q, s1_sq_im_d;
  logic [BIN_W-1:0] s1_bin_q, s1_bin_d;
  logic             s1_last_q, s1_last_d;

  logic             s2_valid_q, s2_valid_d;
  logic [63:0]      s2_power_q, s2_power_d;
  logic [BIN_W-1:0] s2_bin_q, s2_bin_d;
  logic             s2_last_q, s2_last_d;

  logic             s1_load, s2_load, in_xfer, at_last_bin;
  logic signed [63:0] re_ext, im_ext;
  logic [63:0]      sum;

  assign re_ext = {{32{bus.in_data[63]}}, bus.in_data[63:32]};
  assign im_ext = {{32{bus.in_data[31]}}, bus.in_data[31:0]};
  assign sum    = s1_sq_re_q + s1_sq_im_q;

  // A stage loads when it is empty or its current content moves on this cycle.
  assign s2_load     = !s2_valid_q || bus.out_ready;
  assign s1_load     = !s1_valid_q || s2_load;
  assign bus.in_ready = !rst && s1_load;
  assign in_xfer     = bus.in_valid && bus.in_ready;
  assign at_last_bin = (in_bin_q == LAST_BIN);

  always_comb begin
    in_bin_d    = in_bin_q;
    frame_err_d = 1'b0;
    s1_valid_d  = s1_valid_q;
    s1_sq_re_d  = s1_sq_re_q;
    s1_sq_im_d  = s1_sq_im_q;
    s1_bin_d    = s1_bin_q;
    s1_last_d   = s1_last_q;
    s2_valid_d  = s2_valid_q;
    s2_power_d  = s2_power_q;
    s2_bin_d    = s2_bin_q;
    s2_last_d   = s2_last_q;

    // An early in_last restarts the count; a late one is flagged but wraps anyway.
    if (in_xfer) begin
      frame_err_d = (bus.in_last != at_last_bin);
      in_bin_d    = (bus.in_last || at_last_bin) ? '0 : in_bin_q + 1'b1;
    end

    if (s1_load) begin
      s1_valid_d = in_xfer && (in_bin_q <= HALF_BIN);
      s1_sq_re_d = 64'(re_ext * re_ext);
      s1_sq_im_d = 64'(im_ext * im_ext);
      s1_bin_d   = in_bin_q;
      s1_last_d  = (in_bin_q == HALF_BIN);
    end

    if (s2_load) begin
      s2_valid_d = s1_valid_q;
`ifdef POWER_Q_SCALE_EN
      s2_power_d = (sum + 64'h0000_0000_4000_0000) >> 31;
`else
      s2_power_d = sum;
`endif
      s2_bin_d   = s1_bin_q;
      s2_last_d  = s1_last_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_bin_q    <= '0;
      frame_err_q <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_sq_re_q  <= '0;
      s1_sq_im_q  <= '0;
      s1_bin_q    <= '0;
      s1_last_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_power_q  <= '0;
      s2_bin_q    <= '0;
      s2_last_q   <= 1'b0;
    end else begin
      in_bin_q    <= in_bin_d;
      frame_err_q <= frame_err_d;
      s1_valid_q  <= s1_valid_d;
      s1_sq_re_q  <= s1_sq_re_d;
      s1_sq_im_q  <= s1_sq_im_d;
      s1_bin_q    <= s1_bin_d;
      s1_last_q   <= s1_last_d;
      s2_valid_q  <= s2_valid_d;
      s2_power_q  <= s2_power_d;
      s2_bin_q    <= s2_bin_d;
      s2_last_q   <= s2_last_d;
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.out_power = s2_power_q;
  assign bus.out_bin   = s2_bin_q;
  assign bus.out_last  = s2_last_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_fft_power_spectrum.sv
// tb/tb_fft_power_spectrum.sv - table vectors plus randomized frames against a behavioural power model
module tb_fft_power_spectrum;
  localparam int N    = 8;
  localparam int HALF = N / 2;

  typedef struct {
    logic [31:0] re;
    logic [31:0] im;
    logic [63:0] exp_raw;
    logic [63:0] exp_scl;
  } vec_t;

  typedef struct {
    logic [63:0] power;
    logic [2:0]  bin;
    logic        last;
  } out_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_power_spectrum_if #(.BIN_W(3)) bus ();
  fft_power_spectrum #(.FFT_SIZE(N), .BIN_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   m_bin = 0;
  int   err_seen = 0;
  int   first_in_cyc = -1;
  int   first_out_cyc = -1;
  bit   err_exp = 0;
  bit   last_accept = 0;
  bit   stall_prev = 0;
  logic [63:0] prev_power;
  logic [2:0]  prev_bin;
  logic        prev_last;
  out_t rx_q[$];
  out_t exp_q[$];
  vec_t tbl[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Power straight from the definition, in wide signed arithmetic.
  function automatic logic [63:0] model_power(input logic [31:0] re, input logic [31:0] im);
    logic signed [127:0] r, i, p;
    r = 128'(signed'(re));
    i = 128'(signed'(im));
    p = r * r + i * i;
`ifdef POWER_Q_SCALE_EN
    p = (p + (128'sd1 <<< 30)) >>> 31;
`endif
    return p[63:0];
  endfunction

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(9))
      0:       return 32'h8000_0000;
      1:       return 32'h7fff_ffff;
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    out_t o;
    int   b;
    #1;
    cyc++;
    chk("frame_err", {63'd0, bus.frame_err}, {63'd0, err_exp});
    if (bus.frame_err) err_seen++;
    if (stall_prev) begin
      chk("stall_power", bus.out_power, prev_power);
      chk("stall_tag", {59'd0, bus.out_valid, bus.out_bin, bus.out_last}, {59'd0, 1'b1, prev_bin, prev_last});
    end
    if (first_out_cyc < 0 && bus.out_valid) first_out_cyc = cyc;
    if (bus.out_valid && bus.out_ready) begin
      o.power = bus.out_power; o.bin = bus.out_bin; o.last = bus.out_last;
      rx_q.push_back(o);
    end
    stall_prev = bus.out_valid && !bus.out_ready && !rst;
    prev_power = bus.out_power; prev_bin = bus.out_bin; prev_last = bus.out_last;
    last_accept = bus.in_valid && bus.in_ready;
    err_exp = 0;
    if (last_accept) begin
      if (first_in_cyc < 0) first_in_cyc = cyc;
      b = m_bin;
      if (b <= HALF) begin
        o.power = model_power(bus.in_data[63:32], bus.in_data[31:0]);
        o.bin = 3'(b); o.last = (b == HALF);
        exp_q.push_back(o);
      end
      err_exp = (bus.in_last != (b == N - 1));
      m_bin = (bus.in_last || b == N - 1) ? 0 : b + 1;
    end
    @(negedge clk);
  endtask

  task automatic send_bins(input int n, input int last_idx, input bit rnd,
                           input logic [31:0] re, input logic [31:0] im,
                           input int vpct, input int rpct);
    for (int i = 0; i < n; i++) begin
      int guard = 0;
      bit done = 0;
      while (!done) begin
        bus.in_valid  = ($urandom_range(99) < vpct);
        bus.in_last   = (i == last_idx);
        bus.in_data   = rnd ? {rnd_word(), rnd_word()} : {re, im};
        bus.out_ready = ($urandom_range(99) < rpct);
        tick();
        done = last_accept;
        guard++;
        if (!done && guard > 200) begin
          chk("send_timeout", 64'd0, 64'd1);
          done = 1;
        end
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (6) tick();
  endtask

  task automatic check_queues(input string tag);
    int n;
    chk({tag, "_count"}, 64'(rx_q.size()), 64'(exp_q.size()));
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_power"}, rx_q[i].power, exp_q[i].power);
      chk({tag, "_tag"}, {60'd0, rx_q[i].bin, rx_q[i].last}, {60'd0, exp_q[i].bin, exp_q[i].last});
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int e0;
    tbl[0] = '{32'd3,          32'd4,          64'd25,                  64'd0};
    tbl[1] = '{32'h8000_0000,  32'h8000_0000,  64'h8000_0000_0000_0000, 64'h0000_0001_0000_0000};
    tbl[2] = '{32'h7fff_ffff,  32'd0,          64'h3fff_ffff_0000_0001, 64'h0000_0000_7fff_fffe};
    tbl[3] = '{32'd0,          32'd0,          64'd0,                   64'd0};
    tbl[4] = '{32'hffff_fffd,  32'd4,          64'd25,                  64'd0};
    tbl[5] = '{32'h4000_0000,  32'h4000_0000,  64'h2000_0000_0000_0000, 64'h0000_0000_4000_0000};

    rst = 1'b1;
    bus.in_valid = 1'b1; bus.in_last = 1'b0; bus.in_data = {32'd3, 32'd4}; bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
      chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("rst_frame_err", {63'd0, bus.frame_err}, 64'd0);
      @(negedge clk);
    end
    rst = 1'b0;
    bus.in_valid = 1'b0;

    for (int t = 0; t < 6; t++) begin
      logic [63:0] want;
`ifdef POWER_Q_SCALE_EN
      want = tbl[t].exp_scl;
`else
      want = tbl[t].exp_raw;
`endif
      rx_q.delete(); exp_q.delete();
      send_bins(N, N - 1, 1'b0, tbl[t].re, tbl[t].im, 100, 100);
      drain();
      chk("tbl_count", 64'(rx_q.size()), 64'd5);
      for (int k = 0; k < rx_q.size() && k < 5; k++) begin
        chk("tbl_power", rx_q[k].power, want);
        chk("tbl_tag", {60'd0, rx_q[k].bin, rx_q[k].last}, {60'd0, 3'(k), (k == 4)});
      end
      if (t == 0) chk("latency", 64'(first_out_cyc - first_in_cyc), 64'd2);
    end
    rx_q.delete(); exp_q.delete();

    e0 = err_seen;
    send_bins(6, 5, 1'b0, 32'd5, 32'd12, 100, 100);
    send_bins(N, N - 1, 1'b0, 32'd1, 32'd2, 100, 100);
    drain();
    chk("early_last_errs", 64'(err_seen - e0), 64'd1);
    chk("early_last_next_bin", {61'd0, rx_q.size() > 5 ? rx_q[5].bin : 3'd7}, 64'd0);
    check_queues("early_last");

    e0 = err_seen;
    send_bins(N, -1, 1'b1, 32'd0, 32'd0, 100, 100);
    send_bins(N, N - 1, 1'b1, 32'd0, 32'd0, 100, 100);
    drain();
    chk("missing_last_errs", 64'(err_seen - e0), 64'd1);
    check_queues("missing_last");

    send_bins(3, -1, 1'b0, 32'd7, 32'd7, 100, 100);
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("midrst_rx_before", 64'(rx_q.size()), 64'd1);
    chk("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    rx_q.delete(); exp_q.delete(); m_bin = 0;
    send_bins(N, N - 1, 1'b0, 32'd6, 32'hffff_fff8, 100, 100);
    drain();
    check_queues("midrst");

    for (int f = 0; f < 100; f++) send_bins(N, N - 1, 1'b1, 32'd0, 32'd0, 70, 50);
    drain();
    chk("random_total", 64'(rx_q.size()), 64'd500);
    check_queues("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
